// File: rtl/rs232_pkg.sv
// Shared types and constants for the rs232 memory-side scheduler.
package rs232_pkg;

  localparam int WORD_W     = 8;
  localparam int TX_GAP_DEF = 12;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_SKIP   = 2'd1,
    R_SAMPLE = 2'd2,
    R_COMMIT = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_REQ   = 2'd1,
    T_SHIFT = 2'd2,
    T_GAP   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rs232_word_fifo.sv
// Circular word buffer: register array, wrapping pointers, occupancy count.
module rs232_word_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              wr_ok_s, rd_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign wr_ok_s   = wr_en_i & ~full_o;
  assign rd_ok_s   = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rs232_mem_sched.sv
// Memory-side sequencer for rs232_ctrl: deserialises received words into a
// circular buffer and paces their re-transmission one word per Tx slot.
module rs232_mem_sched
  import rs232_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int TX_GAP = TX_GAP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_rs232_en_i,
  input  logic              new_word_i,
  input  logic              data_rs232_in_i,
  output logic              send_word_o,
  output logic              data_rs232_out_o,
  input  logic              echo_en_i,
  input  logic              clr_ovf_i,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              rx_valid_o,
  output logic [AW:0]       fill_level_o,
  output logic              overflow_o,
  output logic              tx_busy_o
);

  localparam int GW = $clog2(TX_GAP + 1);

  rx_state_e         rx_state_q, rx_state_d;
  tx_state_e         tx_state_q, tx_state_d;
  logic              nw_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d, sh_cnt_q, sh_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d, rx_word_q, rx_word_d, txreg_q, txreg_d;
  logic              rx_valid_q, rx_valid_d, ovf_q, ovf_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              commit_s, wr_en_s, rd_en_s, full_s, empty_s;
  logic [WORD_W-1:0] rd_data_s;

  rs232_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_s),
    .wr_data_i (shreg_q),
    .rd_en_i   (rd_en_s),
    .rd_data_o (rd_data_s),
    .count_o   (fill_level_o),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );

  assign commit_s = (rx_state_q == R_COMMIT);
  assign wr_en_s  = commit_s & ~full_s;
  assign rd_en_s  = (tx_state_q == T_REQ);
  // A drop on a full buffer outranks a simultaneous clear.
  assign ovf_d    = (commit_s & full_s) ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);

  // Rx framing: skip one cycle after the rising edge, then take 8 samples.
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_word_d  = rx_word_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (new_word_i && !nw_q) rx_state_d = R_SKIP;
        else                     rx_state_d = R_IDLE;
      end
      R_SKIP: begin
        bit_cnt_d = 3'd0;
        if (new_word_i) rx_state_d = R_SAMPLE;
        else            rx_state_d = R_IDLE;
      end
      R_SAMPLE: begin
        if (!new_word_i) begin
          rx_state_d = R_IDLE;
        end else begin
          shreg_d   = {shreg_q[6:0], data_rs232_in_i};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = R_COMMIT;
            rx_word_d  = shreg_d;
            rx_valid_d = 1'b1;
          end else begin
            rx_state_d = R_SAMPLE;
          end
        end
      end
      R_COMMIT: rx_state_d = R_IDLE;
      default:  rx_state_d = R_IDLE;
    endcase
  end

  // Tx pacing; a word committing this cycle counts as available for start.
  always_comb begin
    tx_state_d = tx_state_q;
    txreg_d    = txreg_q;
    sh_cnt_d   = sh_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (tx_state_q)
      T_IDLE: begin
        if (echo_en_i && (!empty_s || wr_en_s)) tx_state_d = T_REQ;
        else                                    tx_state_d = T_IDLE;
      end
      T_REQ: begin
        txreg_d    = rd_data_s;
        sh_cnt_d   = 3'd0;
        tx_state_d = T_SHIFT;
      end
      T_SHIFT: begin
        txreg_d  = {txreg_q[6:0], 1'b0};
        sh_cnt_d = sh_cnt_q + 3'd1;
        if (sh_cnt_q == 3'd7) begin
          tx_state_d = T_GAP;
          gap_cnt_d  = {GW{1'b0}};
        end else begin
          tx_state_d = T_SHIFT;
        end
      end
      T_GAP: begin
        if (clk_rs232_en_i) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
          if (gap_cnt_q == GW'(TX_GAP - 1)) tx_state_d = T_IDLE;
          else                              tx_state_d = T_GAP;
        end else begin
          tx_state_d = T_GAP;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
      nw_q       <= 1'b0;
      bit_cnt_q  <= 3'd0;
      sh_cnt_q   <= 3'd0;
      shreg_q    <= {WORD_W{1'b0}};
      rx_word_q  <= {WORD_W{1'b0}};
      txreg_q    <= {WORD_W{1'b0}};
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      gap_cnt_q  <= {GW{1'b0}};
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      nw_q       <= new_word_i;
      bit_cnt_q  <= bit_cnt_d;
      sh_cnt_q   <= sh_cnt_d;
      shreg_q    <= shreg_d;
      rx_word_q  <= rx_word_d;
      txreg_q    <= txreg_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign send_word_o      = (tx_state_q == T_REQ);
  assign data_rs232_out_o = (tx_state_q == T_SHIFT) & txreg_q[7];
  assign tx_busy_o        = (tx_state_q != T_IDLE);
  assign rx_word_o        = rx_word_q;
  assign rx_valid_o       = rx_valid_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_rs232_mem_sched.sv
// Randomized bench for rs232_mem_sched against a queue-based reference model.
module tb_rs232_mem_sched;

  localparam int DEPTH = 16;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, nw = 1'b0, din = 1'b0;
  logic       echo = 1'b0, clr = 1'b0;
  logic       send_word, dout, rx_valid, overflow, tx_busy;
  logic [7:0] rx_word;
  logic [4:0] fill;

  int         errors = 0, checks = 0, en_cnt = 0;
  logic [7:0] model_q[$];
  logic       m_ovf = 1'b0;

  rs232_mem_sched #(.DEPTH(DEPTH), .AW(4), .TX_GAP(12)) dut (
    .clk_i(clk), .rst_i(rst), .clk_rs232_en_i(en), .new_word_i(nw),
    .data_rs232_in_i(din), .send_word_o(send_word), .data_rs232_out_o(dout),
    .echo_en_i(echo), .clr_ovf_i(clr), .rx_word_o(rx_word), .rx_valid_o(rx_valid),
    .fill_level_o(fill), .overflow_o(overflow), .tx_busy_o(tx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    en = ($urandom_range(0, 2) == 0);
  end

  always @(posedge clk) if (en) en_cnt <= en_cnt + 1;

  // Transmit monitor: every handed-over word must be the oldest stored word.
  initial begin
    logic [7:0] exp_w, got_w;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!rst && send_word) begin
        if (model_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL tx_unexpected: send_word with model empty, required none");
        end else begin
          exp_w = model_q.pop_front();
          got_w = 8'h00;
          aborted = 1'b0;
          for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
            got_w = {got_w[6:0], dout};
          end
          if (!aborted) begin
            checks++;
            if (got_w !== exp_w) begin
              errors++;
              $display("FAIL tx_word: got %h required %h", got_w, exp_w);
            end
          end
        end
      end
    end
  end

  task automatic do_frame(input logic [7:0] w, input int abort_after,
                          input bit echo_last, input bit clr_commit);
    bit seen;
    @(negedge clk); nw = 1'b1; din = 1'($urandom);
    @(negedge clk); din = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == abort_after) begin
        nw = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (rx_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
          errors++;
          $display("FAIL abort_rx_valid: got pulse required none");
        end
        return;
      end
      din = w[7-i];
      if (i == 7 && echo_last) echo = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_word !== w) begin
      errors++;
      $display("FAIL rx_commit: got valid=%b word=%h required valid=1 word=%h", rx_valid, rx_word, w);
    end
    if (model_q.size() < DEPTH) begin
      model_q.push_back(w);
      if (clr_commit) m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b1;
    end
    nw = 1'b0; clr = clr_commit;
    if (echo_last) echo = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_pulse_width: got valid=%b required 0", rx_valid);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (fill == 5'd0 && !tx_busy) done = 1'b1;
    end
    checks++;
    if (!done || model_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got fill=%0d busy=%b model=%0d required 0/0/0", fill, tx_busy, model_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({send_word, dout, rx_word, rx_valid, fill, overflow, tx_busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_values: got sw=%b do=%b rw=%h rv=%b fl=%0d ov=%b tb=%b required all 0",
               send_word, dout, rx_word, rx_valid, fill, overflow, tx_busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_rx_basic();
    bit sw_seen = 1'b0;
    echo = 1'b0;
    do_frame(8'hA5, -1, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (send_word) sw_seen = 1'b1;
    end
    checks++;
    if (fill !== 5'd1 || sw_seen) begin
      errors++;
      $display("FAIL rx_basic: got fill=%0d send_seen=%b required 1/0", fill, sw_seen);
    end
  endtask

  task automatic test_echo();
    logic [7:0] w = 8'h00;
    int base, n;
    bit early = 1'b0, done = 1'b0, got = 1'b0;
    echo = 1'b1; wait_drain(); echo = 1'b0;
    do_frame(8'h3C, -1, 1'b0, 1'b0);
    echo = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (send_word) got = 1'b1;
    end
    echo = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL echo_send: got no send_word required pulse");
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w = {w[6:0], dout};
    end
    checks++;
    if (w !== 8'h3C) begin
      errors++;
      $display("FAIL echo_bits: got %h required 3c", w);
    end
    @(negedge clk);
    base = en_cnt;
    for (int i = 0; i < 600 && !done; i++) begin
      n = en_cnt - base;
      if (n < 12 && !tx_busy) early = 1'b1;
      if (n >= 12) done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (early || !done || tx_busy !== 1'b0 || fill !== 5'd0) begin
      errors++;
      $display("FAIL echo_gap: got early=%b done=%b busy=%b fill=%0d required 0/1/0/0",
               early, done, tx_busy, fill);
    end
  endtask

  task automatic test_overflow();
    echo = 1'b0;
    for (int i = 0; i < 17; i++) do_frame(8'($urandom), -1, 1'b0, 1'b0);
    checks++;
    if (fill !== 5'(model_q.size()) || overflow !== m_ovf || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got fill=%0d ovf=%b required %0d/%b", fill, overflow, model_q.size(), m_ovf);
    end
    do_frame(8'($urandom), -1, 1'b0, 1'b1);
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow_set_wins: got %b required %b", overflow, m_ovf);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; m_ovf = 1'b0;
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow_clear: got %b required %b", overflow, m_ovf);
    end
    echo = 1'b1; wait_drain(); echo = 1'b0;
  endtask

  task automatic test_abort();
    do_frame(8'($urandom), 4, 1'b0, 1'b0);
    checks++;
    if (fill !== 5'(model_q.size())) begin
      errors++;
      $display("FAIL abort_fill: got %0d required %0d", fill, model_q.size());
    end
    do_frame(8'h81, -1, 1'b0, 1'b0);
    checks++;
    if (fill !== 5'd1) begin
      errors++;
      $display("FAIL abort_next: got fill=%0d required 1", fill);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_frame(8'($urandom), -1, 1'b0, 1'b0);
    do_frame(8'($urandom), -1, 1'b1, 1'b0);
    checks++;
    if (fill !== 5'd5 || model_q.size() != 5) begin
      errors++;
      $display("FAIL coincide_fill: got fill=%0d model=%0d required 5", fill, model_q.size());
    end
    for (int i = 0; i < 14; i++) begin
      echo = 1'($urandom);
      do_frame(8'($urandom), -1, 1'b0, 1'b0);
    end
    echo = 1'b1; wait_drain(); echo = 1'b0;
  endtask

  task automatic test_latency();
    echo = 1'b1;
    do_frame(8'($urandom), -1, 1'b0, 1'b0);
    checks++;
    if (send_word !== 1'b1) begin
      errors++;
      $display("FAIL latency: got send_word=%b in cycle after commit required 1", send_word);
    end
    wait_drain(); echo = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_frame(8'($urandom), -1, 1'b0, 1'b0);
    @(negedge clk); nw = 1'b1; echo = 1'b1;
    @(negedge clk); echo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); din = 1'($urandom);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({send_word, dout, rx_word, rx_valid, fill, overflow, tx_busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_async: got sw=%b do=%b rw=%h rv=%b fl=%0d ov=%b tb=%b required all 0",
               send_word, dout, rx_word, rx_valid, fill, overflow, tx_busy);
    end
    model_q.delete(); m_ovf = 1'b0;
    nw = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    do_frame(8'($urandom), -1, 1'b0, 1'b0);
    checks++;
    if (fill !== 5'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: got fill=%0d ovf=%b required 1/0", fill, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_echo();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
